instruction_cycle_controller: RTL and testbench
===============================================

# instruction_cycle_controller

Sequences the Mano basic computer's instruction cycle: fetch, decode, indirect, execute and interrupt. It consumes the one-hot timing signals from the sequence counter and drives that counter's clear input. It owns the run/stop (S) and interrupt-cycle (R) flip-flops and emits the fetch, decode and interrupt micro-operation strobes. Execute-phase micro-ops belong to a separate execute decoder, which reports completion back to this block.

## Interface
- `BITS`, default 4: sequence-counter width; the timer input is 2**BITS one-hot.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n_in` input 1: asynchronous, active-low reset.
- `timer_in` input 2**BITS: one-hot Tn from the sequence counter.
- `opcode_in` input 4: IR[15:12], the I bit plus three opcode bits.
- `ien_in`, `fgi_in`, `fgo_in` input 1 each: interrupt enable and I/O flags.
- `start_in` input 1: leave HALTED.
- `halt_in` input 1: HLT executed; only honoured in EXECUTE.
- `execute_done_in` input 1: last execute step this cycle; only honoured in EXECUTE.
- `sc_clear_out` output 1: to the sequence counter's `clear_in`.
- `phase_out` output `phase_t`: current phase.
- `step_out` output BITS: shadow step index.
- `fault_out` output 1: sticky timing fault.
- `ops_out` output `cycle_ops_t`: fetch/interrupt strobes, one bit each:
  - `ar_load_pc`, `ir_load_mem`, `pc_inc`, `ar_load_ir`, `decode_load`
  - `ar_load_mem`, `ar_clear`, `tr_load_pc`, `mem_write_tr`, `pc_clear`, `ien_clear`
- `execute_out` output 1: execute decoder enable.

## Operation
- Phases:
  - HALTED
  - FETCH (T0–T1)
  - DECODE (T2)
  - INDIRECT (T3, memory-reference only)
  - EXECUTE
  - INTERRUPT (T0–T2)
- Reset (async) sets:
  - S=0, R=0, phase HALTED, step 0, fault 0
  - `sc_clear_out`=1, all strobes 0, `execute_out`=0
- HALTED:
  - `sc_clear_out`=1 continuously.
  - `start_in` sets S=1; the next edge enters FETCH at T0, or INTERRUPT if R=1.
- FETCH:
  - T0 asserts `ar_load_pc`.
  - T1 asserts `ir_load_mem` and `pc_inc`.
- DECODE (T2):
  - Asserts `decode_load` and `ar_load_ir`.
  - Opcode bits = 7: next edge goes to EXECUTE (register-reference/IO executes from T3).
  - Otherwise: next edge goes to INDIRECT.
- INDIRECT (T3):
  - `ar_load_mem` asserted iff I=1.
  - Next edge goes to EXECUTE (memory-reference executes from T4).
- EXECUTE:
  - `execute_out`=1.
  - `execute_done_in` asserts `sc_clear_out` that cycle.
  - Next phase is FETCH, or INTERRUPT if R=1.
- INTERRUPT:
  - T0: `ar_clear`, `tr_load_pc`.
  - T1: `mem_write_tr`, `pc_clear`.
  - T2: `pc_inc`, `ien_clear`, `sc_clear_out`; R cleared; next phase FETCH.
- R set rule: R is set at an edge when all of the following hold:
  - S=1
  - phase is not INTERRUPT
  - step ≥ 3
  - `ien_in` & (`fgi_in` | `fgo_in`)
- Halt:
  - `halt_in` in EXECUTE clears S and asserts `sc_clear_out`; next phase HALTED.
  - `halt_in` wins over a simultaneous `execute_done_in`.
- `start_in` outside HALTED is ignored.
- Shadow step:
  - Reset or `sc_clear_out` sets step to 0; otherwise step+1 each edge.
- Fault detection applies outside HALTED. A fault is any of:
  - `timer_in` is not one-hot
  - `timer_in` ≠ 1<<step
  - step = 2**BITS−1 without `execute_done_in` or `halt_in` (counter would wrap)
- On fault: set `fault_out` (sticky until reset), clear S, enter HALTED. Faults take precedence over all other events that cycle.

## Timing
- Strobes, `execute_out` and `sc_clear_out` are combinational from registered phase/S/R and the current `timer_in`. They are valid for the whole cycle and act at the closing edge.
- Phase, S, R, step and fault are registered and change only at edges (except async reset).
- Opcode decision latency is zero: EXECUTE starts the cycle after DECODE/INDIRECT.
- Instruction length:
  - Register-reference: T0–T3 minimum.
  - Memory-reference: T0–T4 minimum.
  - Interrupt cycle: exactly 3 cycles.
- Reset deasserted mid-instruction: the block resumes from HALTED only; no partial instruction continues.

## Structure
- `control_pkg` holds:
  - `phase_t` enum
  - `cycle_ops_t` packed struct
  - `OPCODE_REGISTER_IO` = 3'd7
  - step constants `STEP_DECODE` = 2 and `STEP_INDIRECT` = 3
- Sub-module `step_tracker`: shadow counter plus the one-hot/mismatch/wrap check, producing `step_out` and a `timing_fault` signal.

## Test plan
- Reset with `start_in`=0 for 5 cycles → phase HALTED, `sc_clear_out`=1, all strobes 0, `fault_out`=0.
- Start, opcode 4'b0010, `execute_done_in` at T5:
  - T0 `ar_load_pc`, T1 `ir_load_mem`+`pc_inc`, T2 `decode_load`, T3 `ar_load_mem`=0
  - EXECUTE T4–T5, clear at T5, next cycle FETCH T0.
- Opcode 4'b1000 → `ar_load_mem`=1 at T3. Opcode 4'b0111 with done at T3 → EXECUTE at T3, FETCH next cycle.
- `ien_in`=1, `fgi_in`=1 raised at T4 of an instruction finishing at T5:
  - After the clear: INTERRUPT T0–T2 with `ar_clear`/`tr_load_pc`, then `mem_write_tr`/`pc_clear`, then `pc_inc`/`ien_clear`.
  - Then FETCH with R=0.
- `halt_in` and `execute_done_in` together at T4 → HALTED, `sc_clear_out` held. `start_in` pulse → FETCH T0 next cycle.
- Timing faults:
  - Force `timer_in`=16'h0003 during FETCH → `fault_out`=1, HALTED; `start_in` still restarts, fault stays 1 until reset.
  - Withhold `execute_done_in` to T15 → fault.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the basic-computer instruction-cycle controller.
// Phases, fetch/interrupt strobe bundle and the fixed step positions.
package control_pkg;

  typedef enum logic [2:0] {
    PH_HALTED,
    PH_FETCH,
    PH_DECODE,
    PH_INDIRECT,
    PH_EXECUTE,
    PH_INTERRUPT
  } phase_t;

  typedef struct packed {
    logic ar_load_pc;
    logic ir_load_mem;
    logic pc_inc;
    logic ar_load_ir;
    logic decode_load;
    logic ar_load_mem;
    logic ar_clear;
    logic tr_load_pc;
    logic mem_write_tr;
    logic pc_clear;
    logic ien_clear;
  } cycle_ops_t;

  localparam logic [2:0] OPCODE_REGISTER_IO = 3'd7;
  localparam int STEP_DECODE = 2;
  localparam int STEP_INDIRECT = 3;

endpackage

// File: rtl/step_tracker.sv
// Shadow copy of the sequence counter; flags a timer that is not one-hot,
// disagrees with the shadow step, or is about to wrap.
module step_tracker #(
  parameter int BITS = 4
) (
  input  logic              clock,
  input  logic              reset_n_in,
  input  logic [2**BITS-1:0] timer_in,
  input  logic              sc_clear,
  output logic [BITS-1:0]   step_out,
  output logic              timing_fault
);

  localparam int N = 2**BITS;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] expected;
  logic one_hot;
  logic mismatch;
  logic wrap;

  always_comb begin
    expected = ONE << step_out;
    one_hot = (timer_in != '0) &&
              ((timer_in & (timer_in - ONE)) == '0);
    mismatch = (timer_in != expected);
    wrap = (step_out == '1) && !sc_clear;
    timing_fault = !one_hot || mismatch || wrap;
  end

  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      step_out <= '0;
    end else if (sc_clear) begin
      step_out <= '0;
    end else begin
      step_out <= step_out + BITS'(1);
    end
  end

endmodule

// File: rtl/instruction_cycle_controller.sv
// Fetch/decode/indirect/execute/interrupt sequencer for the basic computer.
// Owns the S and R flip-flops and drives the sequence-counter clear.
module instruction_cycle_controller
  import control_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic               clock,
  input  logic               reset_n_in,
  input  logic [2**BITS-1:0] timer_in,
  input  logic [3:0]         opcode_in,
  input  logic               ien_in,
  input  logic               fgi_in,
  input  logic               fgo_in,
  input  logic               start_in,
  input  logic               halt_in,
  input  logic               execute_done_in,
  output logic               sc_clear_out,
  output phase_t             phase_out,
  output logic [BITS-1:0]    step_out,
  output logic               fault_out,
  output cycle_ops_t         ops_out,
  output logic               execute_out
);

  logic s_q;
  logic r_q;
  logic timing_fault;
  logic r_set;
  logic fault_now;

  step_tracker #(.BITS(BITS)) u_step (
    .clock       (clock),
    .reset_n_in  (reset_n_in),
    .timer_in    (timer_in),
    .sc_clear    (sc_clear_out),
    .step_out    (step_out),
    .timing_fault(timing_fault)
  );

  always_comb begin
    ops_out = '0;
    sc_clear_out = 1'b0;
    execute_out = 1'b0;
    unique case (phase_out)
      PH_HALTED: sc_clear_out = 1'b1;
      PH_FETCH: begin
        ops_out.ar_load_pc = timer_in[0];
        ops_out.ir_load_mem = timer_in[1];
        ops_out.pc_inc = timer_in[1];
      end
      PH_DECODE: begin
        ops_out.decode_load = 1'b1;
        ops_out.ar_load_ir = 1'b1;
      end
      PH_INDIRECT: ops_out.ar_load_mem = opcode_in[3];
      PH_EXECUTE: begin
        execute_out = 1'b1;
        sc_clear_out = execute_done_in | halt_in;
      end
      PH_INTERRUPT: begin
        ops_out.ar_clear = timer_in[0];
        ops_out.tr_load_pc = timer_in[0];
        ops_out.mem_write_tr = timer_in[1];
        ops_out.pc_clear = timer_in[1];
        ops_out.pc_inc = timer_in[STEP_DECODE];
        ops_out.ien_clear = timer_in[STEP_DECODE];
        sc_clear_out = timer_in[STEP_DECODE];
      end
      default: sc_clear_out = 1'b1;
    endcase
  end

  always_comb begin
    fault_now = (phase_out != PH_HALTED) && timing_fault;
    r_set = s_q && (phase_out != PH_INTERRUPT) &&
            (step_out >= BITS'(STEP_INDIRECT)) &&
            ien_in && (fgi_in || fgo_in);
  end

  // A timing fault overrides every other event in the same cycle.
  always_ff @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) begin
      phase_out <= PH_HALTED;
      s_q <= 1'b0;
      r_q <= 1'b0;
      fault_out <= 1'b0;
    end else if (fault_now) begin
      fault_out <= 1'b1;
      s_q <= 1'b0;
      phase_out <= PH_HALTED;
    end else begin
      if (r_set) r_q <= 1'b1;
      unique case (phase_out)
        PH_HALTED: begin
          if (start_in) begin
            s_q <= 1'b1;
            phase_out <= r_q ? PH_INTERRUPT : PH_FETCH;
          end
        end
        PH_FETCH: begin
          if (timer_in[STEP_DECODE-1]) phase_out <= PH_DECODE;
        end
        PH_DECODE: begin
          if (opcode_in[2:0] == OPCODE_REGISTER_IO)
            phase_out <= PH_EXECUTE;
          else
            phase_out <= PH_INDIRECT;
        end
        PH_INDIRECT: phase_out <= PH_EXECUTE;
        PH_EXECUTE: begin
          if (halt_in) begin
            s_q <= 1'b0;
            phase_out <= PH_HALTED;
          end else if (execute_done_in) begin
            phase_out <= r_q ? PH_INTERRUPT : PH_FETCH;
          end
        end
        PH_INTERRUPT: begin
          if (timer_in[STEP_DECODE]) begin
            r_q <= 1'b0;
            phase_out <= PH_FETCH;
          end
        end
        default: phase_out <= PH_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cycle_controller.sv
// Directed bench for instruction_cycle_controller driven by a model
// sequence counter that obeys sc_clear_out.
module tb_instruction_cycle_controller;
  import control_pkg::*;

  logic        clock;
  logic        reset_n_in;
  logic [15:0] timer_in;
  logic [3:0]  opcode_in;
  logic        ien_in, fgi_in, fgo_in;
  logic        start_in, halt_in, execute_done_in;
  logic        sc_clear_out;
  phase_t      phase_out;
  logic [3:0]  step_out;
  logic        fault_out;
  cycle_ops_t  ops_out;
  logic        execute_out;

  logic [3:0]  sc;
  logic        force_en;
  logic [15:0] force_val;

  int checks = 0;
  int errors = 0;

  localparam cycle_ops_t NONE = '0;
  localparam cycle_ops_t O_T0 = '{ar_load_pc: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_T1 =
    '{ir_load_mem: 1'b1, pc_inc: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_DEC =
    '{ar_load_ir: 1'b1, decode_load: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_IND = '{ar_load_mem: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_I0 =
    '{ar_clear: 1'b1, tr_load_pc: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_I1 =
    '{mem_write_tr: 1'b1, pc_clear: 1'b1, default: 1'b0};
  localparam cycle_ops_t O_I2 =
    '{pc_inc: 1'b1, ien_clear: 1'b1, default: 1'b0};

  instruction_cycle_controller #(.BITS(4)) dut (
    .clock          (clock),
    .reset_n_in     (reset_n_in),
    .timer_in       (timer_in),
    .opcode_in      (opcode_in),
    .ien_in         (ien_in),
    .fgi_in         (fgi_in),
    .fgo_in         (fgo_in),
    .start_in       (start_in),
    .halt_in        (halt_in),
    .execute_done_in(execute_done_in),
    .sc_clear_out   (sc_clear_out),
    .phase_out      (phase_out),
    .step_out       (step_out),
    .fault_out      (fault_out),
    .ops_out        (ops_out),
    .execute_out    (execute_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n_in) begin
    if (!reset_n_in) sc <= 4'd0;
    else if (sc_clear_out) sc <= 4'd0;
    else sc <= sc + 4'd1;
  end

  assign timer_in = force_en ? force_val : (16'd1 << sc);

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(string tag, phase_t ph, int stp, cycle_ops_t ops,
                     logic clr, logic ex);
    #1;
    chk({tag, " phase"}, 32'(phase_out), 32'(ph));
    chk({tag, " step"}, 32'(step_out), 32'(stp));
    chk({tag, " ops"}, 32'(ops_out), 32'(ops));
    chk({tag, " sc_clear"}, 32'(sc_clear_out), 32'(clr));
    chk({tag, " execute"}, 32'(execute_out), 32'(ex));
  endtask

  task automatic fetch_decode(string tag);
    cyc({tag, " t0"}, PH_FETCH, 0, O_T0, 1'b0, 1'b0);
    tick();
    cyc({tag, " t1"}, PH_FETCH, 1, O_T1, 1'b0, 1'b0);
    tick();
    cyc({tag, " t2"}, PH_DECODE, 2, O_DEC, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n_in = 1'b0;
    opcode_in = 4'd0;
    ien_in = 1'b0; fgi_in = 1'b0; fgo_in = 1'b0;
    start_in = 1'b0; halt_in = 1'b0; execute_done_in = 1'b0;
    force_en = 1'b0; force_val = 16'd0;
    repeat (3) @(posedge clock);
    #1 reset_n_in = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc("reset", PH_HALTED, 0, NONE, 1'b1, 1'b0);
      chk("reset fault", 32'(fault_out), 32'd0);
      tick();
    end

    start_in = 1'b1;
    cyc("start", PH_HALTED, 0, NONE, 1'b1, 1'b0);
    tick();
    start_in = 1'b0;
    opcode_in = 4'b0010;
    fetch_decode("mr");
    tick();
    cyc("mr t3", PH_INDIRECT, 3, NONE, 1'b0, 1'b0);
    tick();
    cyc("mr t4", PH_EXECUTE, 4, NONE, 1'b0, 1'b1);
    tick();
    execute_done_in = 1'b1;
    cyc("mr t5", PH_EXECUTE, 5, NONE, 1'b1, 1'b1);
    tick();
    execute_done_in = 1'b0;

    opcode_in = 4'b1000;
    fetch_decode("ind");
    tick();
    cyc("ind t3", PH_INDIRECT, 3, O_IND, 1'b0, 1'b0);
    tick();
    execute_done_in = 1'b1;
    cyc("ind t4", PH_EXECUTE, 4, NONE, 1'b1, 1'b1);
    tick();
    execute_done_in = 1'b0;

    opcode_in = 4'b0111;
    fetch_decode("rr");
    tick();
    execute_done_in = 1'b1;
    cyc("rr t3", PH_EXECUTE, 3, NONE, 1'b1, 1'b1);
    tick();
    execute_done_in = 1'b0;

    opcode_in = 4'b0010;
    fetch_decode("irq");
    tick();
    cyc("irq t3", PH_INDIRECT, 3, NONE, 1'b0, 1'b0);
    tick();
    ien_in = 1'b1; fgi_in = 1'b1;
    cyc("irq t4", PH_EXECUTE, 4, NONE, 1'b0, 1'b1);
    tick();
    execute_done_in = 1'b1;
    cyc("irq t5", PH_EXECUTE, 5, NONE, 1'b1, 1'b1);
    tick();
    execute_done_in = 1'b0;
    ien_in = 1'b0; fgi_in = 1'b0;
    cyc("irq i0", PH_INTERRUPT, 0, O_I0, 1'b0, 1'b0);
    tick();
    cyc("irq i1", PH_INTERRUPT, 1, O_I1, 1'b0, 1'b0);
    tick();
    cyc("irq i2", PH_INTERRUPT, 2, O_I2, 1'b1, 1'b0);
    tick();

    opcode_in = 4'b0111;
    fetch_decode("post");
    tick();
    execute_done_in = 1'b1;
    cyc("post t3", PH_EXECUTE, 3, NONE, 1'b1, 1'b1);
    tick();
    execute_done_in = 1'b0;

    opcode_in = 4'b0010;
    fetch_decode("hlt");
    tick();
    cyc("hlt t3", PH_INDIRECT, 3, NONE, 1'b0, 1'b0);
    tick();
    halt_in = 1'b1; execute_done_in = 1'b1;
    cyc("hlt t4", PH_EXECUTE, 4, NONE, 1'b1, 1'b1);
    tick();
    halt_in = 1'b0; execute_done_in = 1'b0;
    cyc("hlt idle0", PH_HALTED, 0, NONE, 1'b1, 1'b0);
    tick();
    cyc("hlt idle1", PH_HALTED, 0, NONE, 1'b1, 1'b0);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc("restart", PH_FETCH, 0, O_T0, 1'b0, 1'b0);
    chk("restart fault", 32'(fault_out), 32'd0);

    force_val = 16'h0003;
    force_en = 1'b1;
    #1;
    chk("force phase", 32'(phase_out), 32'(PH_FETCH));
    chk("force fault pre", 32'(fault_out), 32'd0);
    tick();
    force_en = 1'b0;
    #1;
    chk("force halted", 32'(phase_out), 32'(PH_HALTED));
    chk("force fault", 32'(fault_out), 32'd1);
    chk("force sc_clear", 32'(sc_clear_out), 32'd1);
    tick();
    start_in = 1'b1;
    #1;
    chk("fault idle step", 32'(step_out), 32'd0);
    tick();
    start_in = 1'b0;
    cyc("fault restart", PH_FETCH, 0, O_T0, 1'b0, 1'b0);
    chk("fault sticky", 32'(fault_out), 32'd1);

    reset_n_in = 1'b0;
    #1;
    chk("rst2 phase", 32'(phase_out), 32'(PH_HALTED));
    chk("rst2 fault", 32'(fault_out), 32'd0);
    chk("rst2 sc_clear", 32'(sc_clear_out), 32'd1);
    tick();
    reset_n_in = 1'b1;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    opcode_in = 4'b0010;
    fetch_decode("wrap");
    tick();
    cyc("wrap t3", PH_INDIRECT, 3, NONE, 1'b0, 1'b0);
    for (int s = 4; s <= 15; s++) begin
      tick();
      cyc("wrap exec", PH_EXECUTE, s, NONE, 1'b0, 1'b1);
    end
    chk("wrap fault pre", 32'(fault_out), 32'd0);
    tick();
    #1;
    chk("wrap halted", 32'(phase_out), 32'(PH_HALTED));
    chk("wrap fault", 32'(fault_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
